shift_fu_scheduler: RTL and testbench
=====================================

# shift_fu_scheduler

Shift functional unit for the out-of-order core. It arbitrates between two issue ports, executes SLL/SRL/SRA on a single shared 32-bit left barrel shifter datapath, and buffers the tagged results in a 2-entry output queue. The queue drains to writeback over a valid/ready handshake. It sits between the issue stage and the common writeback bus.

## Interface

**Parameters**
- `TAG_W`, default 6: width of the ROB tag carried with each operation.

**Ports** (clock and reset first)
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-port request valid. Bit 0 is port 0.
- `req_ready` out 2: per-port grant/accept. One-hot or zero.
- `req0_op`, `req1_op` in 2: 00 = SLL, 01 = SRL, 10 = SRA, 11 = pass.
- `req0_a`, `req1_a` in 32: operand.
- `req0_shamt`, `req1_shamt` in 5: shift amount.
- `req0_tag`, `req1_tag` in TAG_W: ROB tag.
- `flush` in 1: synchronous pipeline flush.
- `wb_valid` out 1: result available at queue head.
- `wb_ready` in 1: writeback accepts the head.
- `wb_data` out 32: head result. Driven 0 when `wb_valid` = 0.
- `wb_tag` out TAG_W: head tag. Driven 0 when `wb_valid` = 0.
- `busy` out 1: queue non-empty.

## Operation

- **Accept condition.** `can_accept` = (count < 2) OR (count == 2 AND `wb_valid` AND `wb_ready`), AND NOT `flush`.
- **Arbitration.** Round-robin with a 1-bit `last_grant` register.
  - If both ports are valid, grant the port that is not `last_grant`.
  - If one port is valid, grant it.
  - `req_ready[i]` = `can_accept` AND grant[i]. Ready may depend combinationally on valid.
  - `last_grant` updates to i only on a handshake (`req_valid[i]` AND `req_ready[i]`).
  - Reset value of `last_grant` is 1, so port 0 wins the first contention.
- **Execution.** The granted operand passes combinationally through the shift core in the accepting cycle and the result is written to the queue tail.
  - SLL: A << shamt.
  - SRL: bit-reverse A, left shift, bit-reverse the result.
  - SRA: SRL result OR'd with a sign mask when A[31] = 1. The mask is the bit-reverse of (all-ones << shamt), inverted.
  - pass (op 11): result = A; shamt is ignored.
  - shamt = 0: result = A for every op.
- **Queue.** 2 entries of {data, tag}, with 1-bit read/write pointers and a 2-bit count.
  - Pop when `wb_valid` AND `wb_ready`. Push on any request handshake.
  - Simultaneous push and pop: count unchanged, including when full.
  - Ordering is strict FIFO.
- **Flush.**
  - Clears count and pointers at the next edge. Entries popped in the flush cycle are still considered delivered.
  - No request is accepted in the flush cycle.
  - `last_grant` is unchanged.
- **Reset (`reset_n` low, asynchronous):** count = 0, pointers = 0, `last_grant` = 1.
  - Outputs immediately: `wb_valid` = 0, `wb_data` = 0, `wb_tag` = 0, `req_ready` = 0, `busy` = 0.
  - An in-flight result is discarded.
- **Reserved behaviour.** None. All op encodings are defined.

## Timing

- **Latency.** A request accepted at edge N appears at `wb_valid` in the cycle after edge N (latency 1) when the queue was empty.
- **Throughput.** One operation per cycle when `wb_ready` is held high.
- **Output path.** `wb_valid`, `wb_data` and `wb_tag` are functions of registered queue state only. There is no combinational path from `req_*` to `wb_*`.
- **Combinational ready.** `req_ready` depends combinationally on `req_valid`, `flush`, `wb_ready` and the registered count.
- **Backpressure.** With `wb_ready` = 0 and the queue full, `req_ready` = 0. Holding `wb_valid` high is required until the handshake completes, and `wb_data`/`wb_tag` must stay stable during that time.

## Structure

- **Shared package `shift_pkg`:**
  - Op encodings `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_PASS`.
  - `XLEN` = 32 and `SHAMT_W` = 5.
  - A bit-reverse function.
- **Sub-module `shift_core`** (combinational). Inputs: op, a, shamt. Output: result.
  - Instantiates the existing `left_barrel_shifter` twice: once for the data, once for the all-ones SRA mask.
- **Top level** contains the arbiter, queue and handshake logic only.

## Test plan

1. **SLL.** Port 0: SLL, A = 0x0000_0001, shamt = 31, tag = 5, `wb_ready` = 1 → next cycle `wb_valid` = 1, `wb_data` = 0x8000_0000, `wb_tag` = 5, then `busy` = 0.
2. **SRL/SRA/pass.** A = 0x8000_00F0, shamt = 4:
   - SRL → 0x0800_000F.
   - SRA → 0xF800_000F.
   - SRA with shamt = 0 → 0x8000_00F0.
   - op 11 with shamt = 9 → 0x8000_00F0.
3. **Round-robin fairness.** Both ports valid for 6 cycles with distinct tags, `wb_ready` = 1 → grants 0,1,0,1,0,1, and results emerge in the same order.
4. **Backpressure.** `wb_ready` = 0, three consecutive requests → first two accepted, third sees `req_ready` = 0. Raise `wb_ready` → head pops and the third is accepted in that same cycle (push at full). Output order is 1, 2, 3.
5. **Flush.** Queue holds 2 entries, assert `flush` with port 0 valid → `req_ready` = 0 that cycle. Next cycle `wb_valid` = 0, `busy` = 0, `wb_data` = 0.
6. **Reset mid-operation.** Assert `reset_n` = 0 mid-cycle with 1 entry queued → `wb_valid`, `wb_data`, `req_ready` and `busy` go to 0 without waiting for a clock edge. After release, the first contention grants port 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift functional unit: widths, op encodings
// and a bit-reverse helper used to build right shifts on a left shifter.
package shift_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < int'(XLEN); i++) r[i] = x[XLEN-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_fu_scheduler_if.sv
// Issue-side request ports and writeback-side result port of the shift unit.
interface shift_fu_scheduler_if
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = 6
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  op_e                req0_op;
  op_e                req1_op;
  logic [XLEN-1:0]    req0_a;
  logic [XLEN-1:0]    req1_a;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [TAG_W-1:0]   req0_tag;
  logic [TAG_W-1:0]   req1_tag;
  logic               flush;
  logic               wb_valid;
  logic               wb_ready;
  logic [XLEN-1:0]    wb_data;
  logic [TAG_W-1:0]   wb_tag;
  logic               busy;

  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req1_a,
           req0_shamt, req1_shamt, req0_tag, req1_tag, flush, wb_ready,
    output req_ready, wb_valid, wb_data, wb_tag, busy
  );

  modport master (
    output req_valid, req0_op, req1_op, req0_a, req1_a,
           req0_shamt, req1_shamt, req0_tag, req1_tag, flush, wb_ready,
    input  req_ready, wb_valid, wb_data, wb_tag, busy
  );

endinterface

// File: rtl/left_barrel_shifter.sv
// Logarithmic left barrel shifter: one conditional power-of-two stage per shamt bit.
module left_barrel_shifter #(
  parameter int unsigned W   = 32,
  parameter int unsigned SHW = 5
) (
  input  logic [W-1:0]   data,
  input  logic [SHW-1:0] shamt,
  output logic [W-1:0]   result
);

  logic [W-1:0] stage [SHW+1];

  assign stage[0] = data;

  for (genvar s = 0; s < int'(SHW); s++) begin : g_stage
    assign stage[s+1] = shamt[s] ? (stage[s] << (1 << s)) : stage[s];
  end

  assign result = stage[SHW];

endmodule

// File: rtl/shift_core.sv
// Combinational SLL/SRL/SRA/pass built on a single left barrel shifter;
// right shifts reverse the operand, and a second shifter builds the SRA fill mask.
module shift_core
  import shift_pkg::*;
(
  input  op_e                op,
  input  logic [XLEN-1:0]    a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    result
);

  logic [XLEN-1:0] shl_in;
  logic [XLEN-1:0] shl_out;
  logic [XLEN-1:0] ones_shl;
  logic [XLEN-1:0] srl_res;
  logic [XLEN-1:0] sra_mask;

  assign shl_in = (op == OP_SLL) ? a : bit_reverse(a);

  left_barrel_shifter #(.W(XLEN), .SHW(SHAMT_W)) u_data_shift (
    .data   (shl_in),
    .shamt  (shamt),
    .result (shl_out)
  );

  left_barrel_shifter #(.W(XLEN), .SHW(SHAMT_W)) u_mask_shift (
    .data   ({XLEN{1'b1}}),
    .shamt  (shamt),
    .result (ones_shl)
  );

  assign srl_res  = bit_reverse(shl_out);
  // Top shamt bits set: the vacated positions that a negative operand must fill.
  assign sra_mask = a[XLEN-1] ? ~bit_reverse(ones_shl) : '0;

  always_comb begin
    result = a;
    case (op)
      OP_SLL:  result = shl_out;
      OP_SRL:  result = srl_res;
      OP_SRA:  result = srl_res | sra_mask;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/shift_fu_scheduler.sv
// Shift functional unit: round-robin between two issue ports, shared shift core,
// 2-entry tagged result FIFO draining to writeback over valid/ready.
module shift_fu_scheduler
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  shift_fu_scheduler_if.slave  bus
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic [XLEN-1:0]    q_data [DEPTH];
  logic [TAG_W-1:0]   q_tag  [DEPTH];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               last_grant;

  logic               pop;
  logic               push;
  logic               can_accept;
  logic               any_valid;
  logic               gnt_sel;
  op_e                sel_op;
  logic [XLEN-1:0]    sel_a;
  logic [SHAMT_W-1:0] sel_shamt;
  logic [TAG_W-1:0]   sel_tag;
  logic [XLEN-1:0]    core_result;

  // Writeback side depends only on registered queue state.
  assign bus.wb_valid = (count != '0);
  assign bus.wb_data  = bus.wb_valid ? q_data[rd_ptr] : '0;
  assign bus.wb_tag   = bus.wb_valid ? q_tag[rd_ptr]  : '0;
  assign bus.busy     = bus.wb_valid;
  assign pop          = bus.wb_valid & bus.wb_ready;

  // Arbitration and accept; reset_n gating keeps ready low while in reset.
  always_comb begin
    any_valid  = |bus.req_valid;
    gnt_sel    = 1'b0;
    if (&bus.req_valid) gnt_sel = ~last_grant;
    else                gnt_sel = bus.req_valid[1];
    can_accept = reset_n & ~bus.flush &
                 ((count < CNT_W'(DEPTH)) | ((count == CNT_W'(DEPTH)) & pop));
    push       = can_accept & any_valid;
    bus.req_ready = '0;
    if (push) bus.req_ready = gnt_sel ? 2'b10 : 2'b01;
  end

  assign sel_op    = gnt_sel ? bus.req1_op    : bus.req0_op;
  assign sel_a     = gnt_sel ? bus.req1_a     : bus.req0_a;
  assign sel_shamt = gnt_sel ? bus.req1_shamt : bus.req0_shamt;
  assign sel_tag   = gnt_sel ? bus.req1_tag   : bus.req0_tag;

  shift_core u_core (
    .op     (sel_op),
    .a      (sel_a),
    .shamt  (sel_shamt),
    .result (core_result)
  );

  // Queue control and round-robin state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      last_grant <= 1'b1;
    end else if (bus.flush) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= ~wr_ptr;
        last_grant <= gnt_sel;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data[i] <= '0;
        q_tag[i]  <= '0;
      end
    end else if (push) begin
      q_data[wr_ptr] <= core_result;
      q_tag[wr_ptr]  <= sel_tag;
    end
  end

endmodule

// File: tb/tb_shift_fu_scheduler.sv
// Scoreboard bench for shift_fu_scheduler: expected results queued at request
// handshake, compared in order as the writeback port drains.
module tb_shift_fu_scheduler;
  import shift_pkg::*;

  localparam int unsigned TAG_W = 6;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  shift_fu_scheduler_if #(.TAG_W(TAG_W)) bus ();

  shift_fu_scheduler #(.TAG_W(TAG_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  op_e              cur_op  [2];
  logic [31:0]      cur_a   [2];
  logic [4:0]       cur_sh  [2];
  logic [TAG_W-1:0] cur_tag [2];
  logic [TAG_W-1:0] next_tag = 6'd16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input op_e op, input logic [31:0] a, input logic [4:0] sh);
    case (op)
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return 32'($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  // Writeback monitor: compare head against scoreboard, retire on handshake.
  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (bus.wb_valid) begin
        if (sb.size() == 0) begin
          check("wb_valid_unexp", 32'(bus.wb_valid), 32'd0);
        end else begin
          check("wb_data", bus.wb_data, sb[0].data);
          check("wb_tag", 32'(bus.wb_tag), 32'(sb[0].tag));
          if (bus.wb_ready) void'(sb.pop_front());
        end
      end else begin
        check("idle_data", bus.wb_data, 32'd0);
        check("idle_tag", 32'(bus.wb_tag), 32'd0);
      end
      if (bus.flush) sb.delete();
    end
  end

  task automatic drive(input int port, input op_e op, input logic [31:0] a,
                       input logic [4:0] sh, input logic [TAG_W-1:0] tag);
    cur_op[port]  = op;
    cur_a[port]   = a;
    cur_sh[port]  = sh;
    cur_tag[port] = tag;
    if (port == 0) begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_shamt = sh; bus.req0_tag = tag;
    end else begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_shamt = sh; bus.req1_tag = tag;
    end
    bus.req_valid[port] = 1'b1;
  endtask

  // Waits (bounded) for ready on one port; queues the expected result on grant.
  task automatic send(input int port, input op_e op, input logic [31:0] a,
                      input logic [4:0] sh, input logic [TAG_W-1:0] tag,
                      input logic [31:0] exp);
    int n;
    n = 0;
    drive(port, op, a, sh, tag);
    @(negedge clock);
    while (!bus.req_ready[port] && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("grant", 32'(bus.req_ready[port]), 32'd1);
    if (bus.req_ready[port]) sb.push_back(exp_t'{data: exp, tag: tag});
    @(posedge clock); #1;
    bus.req_valid[port] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clock);
    while (bus.busy && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("drain_busy", 32'(bus.busy), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic new_req(input int port);
    drive(port, op_e'(2'($urandom_range(0, 3))), $urandom, 5'($urandom_range(0, 31)), next_tag);
    next_tag = next_tag + 6'd1;
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req0_op = OP_SLL; bus.req0_a = '0; bus.req0_shamt = '0; bus.req0_tag = '0;
    bus.req1_op = OP_SLL; bus.req1_a = '0; bus.req1_shamt = '0; bus.req1_tag = '0;
    bus.flush = 1'b0;
    bus.wb_ready = 1'b0;

    // Reset: outputs quiet even with requests pending.
    bus.req_valid = 2'b11;
    repeat (2) @(negedge clock);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    bus.req_valid = 2'b00;
    @(posedge clock); #1;
    reset_n = 1'b1;

    // SLL with latency 1.
    bus.wb_ready = 1'b1;
    send(0, OP_SLL, 32'h0000_0001, 5'd31, 6'd5, 32'h8000_0000);
    @(negedge clock);
    check("t1_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("t1_wb_data", bus.wb_data, 32'h8000_0000);
    check("t1_wb_tag", 32'(bus.wb_tag), 32'd5);
    @(negedge clock);
    check("t1_busy", 32'(bus.busy), 32'd0);
    @(posedge clock); #1;

    // SRL / SRA / shamt 0 / pass back-to-back.
    send(0, OP_SRL,  32'h8000_00F0, 5'd4, 6'd6, 32'h0800_000F);
    send(0, OP_SRA,  32'h8000_00F0, 5'd4, 6'd7, 32'hF800_000F);
    send(0, OP_SRA,  32'h8000_00F0, 5'd0, 6'd8, 32'h8000_00F0);
    send(1, OP_PASS, 32'h8000_00F0, 5'd9, 6'd9, 32'h8000_00F0);
    drain();

    // Round robin: port 1 was last, so contention starts at port 0.
    new_req(0);
    new_req(1);
    for (int i = 0; i < 6; i++) begin
      int g;
      @(negedge clock);
      check("rr_grant", 32'(bus.req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      g = bus.req_ready[1] ? 1 : 0;
      if (bus.req_ready != 2'b00)
        sb.push_back(exp_t'{data: model(cur_op[g], cur_a[g], cur_sh[g]), tag: cur_tag[g]});
      @(posedge clock); #1;
      new_req(g);
    end
    bus.req_valid = 2'b00;
    drain();

    // Backpressure: third request blocked until the head pops, then pushes at full.
    bus.wb_ready = 1'b0;
    send(0, OP_SLL, 32'h1, 5'd1, 6'd21, 32'h2);
    send(0, OP_SLL, 32'h1, 5'd2, 6'd22, 32'h4);
    drive(0, OP_SLL, 32'h1, 5'd3, 6'd23);
    @(negedge clock);
    check("bp_ready", 32'(bus.req_ready), 32'd0);
    check("bp_busy", 32'(bus.busy), 32'd1);
    check("bp_head_tag", 32'(bus.wb_tag), 32'd21);
    @(negedge clock);
    check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clock); #1;
    bus.wb_ready = 1'b1;
    @(negedge clock);
    check("bp_push_full", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready[0]) sb.push_back(exp_t'{data: 32'h8, tag: 6'd23});
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    drain();

    // Flush with a full queue and a pending request.
    bus.wb_ready = 1'b0;
    send(0, OP_SRL, 32'hFFFF_0000, 5'd8, 6'd31, 32'h00FF_FF00);
    send(1, OP_SLL, 32'h0000_00FF, 5'd8, 6'd32, 32'h0000_FF00);
    drive(0, OP_PASS, 32'h1234_5678, 5'd0, 6'd33);
    bus.flush = 1'b1;
    @(negedge clock);
    check("flush_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clock); #1;
    bus.flush = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clock);
    check("flush_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_wb_data", bus.wb_data, 32'd0);
    @(posedge clock); #1;

    // Asynchronous reset with one entry queued.
    send(0, OP_SLL, 32'h0000_0003, 5'd4, 6'd40, 32'h30);
    @(negedge clock);
    check("pre_rst_valid", 32'(bus.wb_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    drive(0, OP_SRA, 32'hF000_0000, 5'd4, 6'd41);
    drive(1, OP_SLL, 32'h0000_0003, 5'd1, 6'd42);
    #1;
    check("arst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("arst_wb_data", bus.wb_data, 32'd0);
    check("arst_req_ready", 32'(bus.req_ready), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge clock);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_grant", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready[0]) sb.push_back(exp_t'{data: 32'hFF00_0000, tag: 6'd41});
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    bus.wb_ready = 1'b1;
    drain();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
